// File: rtl/flash_read_responder.sv
// flash_read_responder
//   Avalon-MM read-only responder modelling the flash side of the audio read
//   path. It answers reads from an internal ROM after a fixed latency, with
//   waitRequest backpressure bounded by the number of outstanding reads.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous reset, active low
//   address       in   [22:0] word address of the read
//   read          in   read request
//   byteEnable    in   [3:0] lane enables, bit i gates readData[8i+7:8i]
//   waitRequest   out  high: the current request is not accepted
//   readData      out  [31:0] returned word, held while readDataValid is low
//   readDataValid out  readData valid this cycle
//   addr_err      out  sticky: an out-of-range address was accepted
//
// Optional feature
//   FLASH_RESP_RANDOM_WAIT_EN: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed
//   8'hA5) advances each clock in ST_RUN and forces waitRequest high while
//   its bit 0 is set, modelling flash stalls.
module flash_read_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned MAX_PENDING = 4,
  parameter string       INIT_FILE   = "audio_rom.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] address,
  input  logic        read,
  input  logic [3:0]  byteEnable,
  output logic        waitRequest,
  output logic [31:0] readData,
  output logic        readDataValid,
  output logic        addr_err
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  logic [31:0] rom_mem [DEPTH_WORDS];

  state_e      state_q;
  logic        wait_q, wait_d;
  logic [3:0]  pend_q, pend_d;
  logic        err_q;

  // Request stage: captured on the accepting edge.
  logic          req_v_q;
  logic          req_oor_q;
  logic [IW-1:0] req_idx_q;
  logic [3:0]    req_be_q;

  // Data stages: the last one drives the outputs and only loads when a valid
  // word arrives, so readData holds between returns.
  logic        dv_q [LATENCY];
  logic [31:0] dd_q [LATENCY];
  logic        sv_in [LATENCY];
  logic [31:0] sd_in [LATENCY];

  logic        accept;
  logic        in_range;
  logic        ret;
  logic [31:0] rom_raw, rom_word;

  assign accept   = read & ~wait_q & (state_q == ST_RUN);
  assign in_range = ({9'd0, address} < DEPTH_WORDS);

  always_comb begin
    rom_raw  = req_oor_q ? '0 : rom_mem[req_idx_q];
    rom_word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      rom_word[8*b +: 8] = req_be_q[b] ? rom_raw[8*b +: 8] : 8'h00;
    end
  end

  always_comb begin
    sv_in[0] = req_v_q;
    sd_in[0] = rom_word;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      sv_in[i] = dv_q[i-1];
      sd_in[i] = dd_q[i-1];
    end
  end

  // A return is the edge on which the final stage loads a valid word.
  assign ret    = sv_in[LATENCY-1];
  assign pend_d = pend_q + 4'(accept) - 4'(ret);

`ifdef FLASH_RESP_RANDOM_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_RUN) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign wait_d = (pend_d == 4'(MAX_PENDING)) | lfsr_d[0];
`else
  assign wait_d = (pend_d == 4'(MAX_PENDING));
`endif

  // waitRequest is registered from next-state values, so it reflects the
  // pending count (and LFSR) of the coming cycle without a path from read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      wait_q    <= 1'b1;
      pend_q    <= '0;
      err_q     <= 1'b0;
      req_v_q   <= 1'b0;
      req_oor_q <= 1'b0;
      req_idx_q <= '0;
      req_be_q  <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dv_q[i] <= 1'b0;
        dd_q[i] <= '0;
      end
`ifdef FLASH_RESP_RANDOM_WAIT_EN
      lfsr_q    <= 8'hA5;
`endif
    end else begin
      state_q <= ST_RUN;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      req_v_q <= accept;
      if (accept) begin
        req_oor_q <= ~in_range;
        req_idx_q <= address[IW-1:0];
        req_be_q  <= byteEnable;
        if (!in_range) err_q <= 1'b1;
      end
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dv_q[i] <= sv_in[i];
        if (sv_in[i]) dd_q[i] <= sd_in[i];
      end
`ifdef FLASH_RESP_RANDOM_WAIT_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign waitRequest   = wait_q;
  assign readDataValid = dv_q[LATENCY-1];
  assign readData      = dd_q[LATENCY-1];
  assign addr_err      = err_q;

endmodule
